// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl
// Frame sequencer for the 3x3 streaming convolution datapath. A start pulse
// clears the datapath, streams one W x H frame out of the source RAM, tracks
// the window position of every issued pixel and writes each valid result to
// the destination RAM, then pulses done.
//
// Ports
//   clk       clock, all logic on rising edge
//   reset     synchronous, active-high
//   start     one-cycle frame request, honoured only in IDLE
//   abort     cancel the current frame (PRIME/RUN/FLUSH)
//   busy      high in every state except IDLE
//   done      one-cycle pulse at frame completion
//   conv_rst  synchronous clear to the datapath registers
//   rd_en     source RAM read enable
//   rd_addr   source pixel index, row*W+col
//   conv_pxl  datapath result
//   wr_en     destination RAM write enable
//   wr_addr   destination index
//   wr_data   destination data
//
// Build option CONV_CTRL_BORDER_EN: every issued pixel is written at its own
// source index, with border pixels forced to 8'h00.
//
// state   | meaning
// IDLE    | waiting for start
// PRIME   | one cycle, datapath cleared, counters zeroed
// RUN     | W*H cycles issuing source reads
// FLUSH   | RD_LAT+LAT cycles draining the window delay line
// DONE    | one-cycle done pulse

module conv_frame_ctrl #(
    parameter int W      = 220,
    parameter int H      = 220,
    parameter int K      = 3,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              conv_rst,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        conv_pxl,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int D  = RD_LAT + LAT;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
`ifdef CONV_CTRL_BORDER_EN
    localparam int N_OUT = W * H;
`else
    localparam int N_OUT = (W - K + 1) * (H - K + 1);
`endif
    // One extra code so the counter can sit at N_OUT after the last write.
    localparam int OW = $clog2(N_OUT + 1);
    localparam int FW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [OW-1:0]   out_cnt;
    logic [FW-1:0]   fl_cnt;
    logic [D-1:0]    win_dly;
    logic            win_cur;
    logic            last_pix;
    logic            abort_ok;

    assign win_cur  = (state == S_RUN) && (int'(row) >= K - 1) && (int'(col) >= K - 1);
    assign last_pix = (int'(row) == H - 1) && (int'(col) == W - 1);
    assign abort_ok = abort && (state == S_PRIME || state == S_RUN || state == S_FLUSH);

`ifdef CONV_CTRL_BORDER_EN
    logic [D-1:0] en_dly;

    // Every issued pixel is written; the write counter then tracks the
    // source index exactly because pixels are issued in raster order.
    assign wr_en   = en_dly[D-1];
    assign wr_data = win_dly[D-1] ? conv_pxl : 8'h00;
`else
    assign wr_en   = win_dly[D-1];
    assign wr_data = wr_en ? conv_pxl : 8'h00;
`endif
    assign wr_addr = ADDR_W'(out_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            conv_rst <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            col      <= '0;
            row      <= '0;
            out_cnt  <= '0;
            fl_cnt   <= '0;
            win_dly  <= '0;
`ifdef CONV_CTRL_BORDER_EN
            en_dly   <= '0;
`endif
        end else begin
            win_dly  <= {win_dly[D-2:0], win_cur};
`ifdef CONV_CTRL_BORDER_EN
            en_dly   <= {en_dly[D-2:0], rd_en};
`endif
            conv_rst <= 1'b0;
            done     <= 1'b0;
            if (wr_en) begin
                out_cnt <= out_cnt + OW'(1);
            end

            if (abort_ok) begin
                // Cancelled frame: clear the datapath and drop pending writes.
                state    <= S_IDLE;
                busy     <= 1'b0;
                conv_rst <= 1'b1;
                rd_en    <= 1'b0;
                win_dly  <= '0;
`ifdef CONV_CTRL_BORDER_EN
                en_dly   <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_PRIME;
                            busy     <= 1'b1;
                            conv_rst <= 1'b1;
                            rd_addr  <= '0;
                            col      <= '0;
                            row      <= '0;
                            out_cnt  <= '0;
                        end
                    end
                    S_PRIME: begin
                        state <= S_RUN;
                        rd_en <= 1'b1;
                    end
                    S_RUN: begin
                        if (last_pix) begin
                            state  <= S_FLUSH;
                            rd_en  <= 1'b0;
                            fl_cnt <= FW'(D - 1);
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                            if (int'(col) == W - 1) begin
                                col <= '0;
                                row <= row + RW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (fl_cnt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            fl_cnt <= fl_cnt - FW'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
module tb_conv_frame_ctrl;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int NT = 40;
`ifdef CONV_CTRL_BORDER_EN
    localparam int NW_EXP  = 25;
    localparam int FIRST_T = 5;
`else
    localparam int NW_EXP  = 9;
    localparam int FIRST_T = 17;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, conv_rst, rd_en, wr_en;
    logic [15:0] rd_addr, wr_addr;
    logic [7:0]  conv_pxl, wr_data;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign conv_pxl = cyc[7:0];

    conv_frame_ctrl #(.W(W), .H(H), .K(3), .ADDR_W(16), .RD_LAT(1), .LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .conv_rst(conv_rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .conv_pxl(conv_pxl),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        int t; int rd_en; int rd_addr; int conv_rst; int busy; int done;
    } vec_t;

    typedef struct {
        int rd_en; int rd_addr; int conv_rst; int busy; int done;
        int wr_en; int wr_addr; int wr_data; int cyc;
    } smp_t;

    vec_t tbl[11];
    smp_t lg[NT];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tot++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endtask

    // Runs NT cycles; start is driven at t=0 (plus extra starts when noise
    // is set), abort/reset for one cycle at the given t (-1 = never).
    task automatic run(input bit noise, input int abort_t, input int reset_t);
        for (int t = 0; t < NT; t++) begin
            @(negedge clk);
            lg[t].rd_en    = int'(rd_en);
            lg[t].rd_addr  = int'(rd_addr);
            lg[t].conv_rst = int'(conv_rst);
            lg[t].busy     = int'(busy);
            lg[t].done     = int'(done);
            lg[t].wr_en    = int'(wr_en);
            lg[t].wr_addr  = int'(wr_addr);
            lg[t].wr_data  = int'(wr_data);
            lg[t].cyc      = cyc;
            start = (t == 0) || (noise && (t == 5 || t == 10 || t == 30));
            abort = (t == abort_t);
            reset = (t == reset_t);
        end
    endtask

    task automatic check_frame(input string tag);
        int nwr, first_t, ndone, rd_bad, p, exp_d;
        for (int i = 0; i < 11; i++) begin
            smp_t s;
            s = lg[tbl[i].t];
            chk($sformatf("%s t%0d rd_en", tag, tbl[i].t), s.rd_en, tbl[i].rd_en);
            chk($sformatf("%s t%0d conv_rst", tag, tbl[i].t), s.conv_rst, tbl[i].conv_rst);
            chk($sformatf("%s t%0d busy", tag, tbl[i].t), s.busy, tbl[i].busy);
            chk($sformatf("%s t%0d done", tag, tbl[i].t), s.done, tbl[i].done);
            if (tbl[i].rd_addr >= 0)
                chk($sformatf("%s t%0d rd_addr", tag, tbl[i].t), s.rd_addr, tbl[i].rd_addr);
        end
        nwr = 0; first_t = -1; ndone = 0; rd_bad = 0;
        for (int t = 1; t < NT; t++) begin
            if (lg[t].rd_en != ((t >= 2 && t <= 26) ? 1 : 0)) rd_bad++;
            else if (lg[t].rd_en == 1 && lg[t].rd_addr != t - 2) rd_bad++;
            if (lg[t].done == 1) ndone++;
            if (lg[t].wr_en == 1) begin
                if (first_t < 0) first_t = t;
                p = t - 5;
                chk($sformatf("%s wr_addr t%0d", tag, t), lg[t].wr_addr, nwr);
`ifdef CONV_CTRL_BORDER_EN
                chk($sformatf("%s src_idx t%0d", tag, t), lg[t].wr_addr, p);
                exp_d = (p / W >= 2 && p % W >= 2) ? (lg[t].cyc & 255) : 0;
`else
                chk($sformatf("%s interior t%0d", tag, t),
                    (p >= 0 && p < W * H && p / W >= 2 && p % W >= 2) ? 1 : 0, 1);
                exp_d = lg[t].cyc & 255;
`endif
                chk($sformatf("%s wr_data t%0d", tag, t), lg[t].wr_data, exp_d);
                nwr++;
            end
        end
        chk({tag, " rd_seq_errors"}, rd_bad, 0);
        chk({tag, " write_count"}, nwr, NW_EXP);
        chk({tag, " first_write_t"}, first_t, FIRST_T);
        chk({tag, " done_count"}, ndone, 1);
    endtask

    initial begin
        int bad;
        tbl[0]  = '{0,  0, -1, 0, 0, 0};
        tbl[1]  = '{1,  0, -1, 1, 1, 0};
        tbl[2]  = '{2,  1,  0, 0, 1, 0};
        tbl[3]  = '{3,  1,  1, 0, 1, 0};
        tbl[4]  = '{14, 1, 12, 0, 1, 0};
        tbl[5]  = '{26, 1, 24, 0, 1, 0};
        tbl[6]  = '{27, 0, -1, 0, 1, 0};
        tbl[7]  = '{29, 0, -1, 0, 1, 0};
        tbl[8]  = '{30, 0, -1, 0, 1, 1};
        tbl[9]  = '{31, 0, -1, 0, 0, 0};
        tbl[10] = '{32, 0, -1, 0, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst conv_rst", int'(conv_rst), 0);
        chk("rst rd_en", int'(rd_en), 0);
        chk("rst rd_addr", int'(rd_addr), 0);
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst wr_addr", int'(wr_addr), 0);
        chk("rst wr_data", int'(wr_data), 0);
        reset = 1'b0;

        // Frame with stray starts during RUN and on the DONE cycle
        run(1'b1, -1, -1);
        check_frame("f1");
        // Second identical frame
        run(1'b0, -1, -1);
        check_frame("f2");

        // Abort at RUN cycle 10
        run(1'b0, 12, -1);
        chk("abort conv_rst", lg[13].conv_rst, 1);
        chk("abort busy", lg[13].busy, 0);
        chk("abort rd_en", lg[13].rd_en, 0);
        chk("abort wr_en", lg[13].wr_en, 0);
        bad = 0;
        for (int t = 13; t < NT; t++)
            if (lg[t].wr_en != 0 || lg[t].done != 0 || lg[t].busy != 0) bad++;
        chk("abort quiet_after", bad, 0);
        run(1'b0, -1, -1);
        check_frame("f3");

        // Reset mid-FLUSH (cycle 28), pending write would land at 29
        run(1'b0, -1, 28);
        chk("flushrst busy", lg[29].busy, 0);
        chk("flushrst done", lg[29].done, 0);
        chk("flushrst conv_rst", lg[29].conv_rst, 0);
        chk("flushrst rd_en", lg[29].rd_en, 0);
        chk("flushrst rd_addr", lg[29].rd_addr, 0);
        chk("flushrst wr_en", lg[29].wr_en, 0);
        chk("flushrst wr_addr", lg[29].wr_addr, 0);
        chk("flushrst wr_data", lg[29].wr_data, 0);
        bad = 0;
        for (int t = 29; t < NT; t++)
            if (lg[t].wr_en != 0 || lg[t].done != 0) bad++;
        chk("flushrst quiet_after", bad, 0);

        // Controller usable again after the reset
        run(1'b0, -1, -1);
        check_frame("f4");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
